// File: rtl/audio_pdm_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : audio_pdm_tx                                               |
// | Description : PCM-to-PDM audio transmitter. An 8-bit offset-binary       |
// |               sample stream is buffered in a 4-entry FIFO and converted  |
// |               to a 1-bit PDM stream by a first-order sigma-delta         |
// |               modulator running at clk/CLK_DIV, with OSR PDM bits per    |
// |               sample.                                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   system clock, rising edge                              |
// |   reset      in   synchronous active-low reset                           |
// |   din[7:0]   in   PCM sample, offset binary (0x80 = silence)             |
// |   din_valid  in   producer has a sample on din                           |
// |   din_ready  out  FIFO not full, sample accepted when din_valid is high  |
// |   enable     in   playback enable                                        |
// |   mclk       out  PDM bit clock, high in first half of each bit period   |
// |   ampPWM     out  registered PDM bitstream                                |
// |   ampSD      out  amplifier shutdown-not, registered enable              |
// |   underrun   out  one-cycle pulse: a sample load found the FIFO empty    |
// |   fifo_level out  FIFO occupancy 0..4                                    |
// +--------------------------------------------------------------------------+
module audio_pdm_tx #(
   parameter int CLK_DIV = 50,
   parameter int OSR     = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       enable,
   output logic       mclk,
   output logic       ampPWM,
   output logic       ampSD,
   output logic       underrun,
   output logic [2:0] fifo_level
);

   localparam int               DIV_W      = $clog2(CLK_DIV);
   localparam int               BIT_W      = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(OSR - 1);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam logic [2:0]       FIFO_DEPTH = 3'd4;
   localparam logic [7:0]       SILENCE    = 8'h80;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       cur_sample_q, cur_sample_d;
   logic [7:0]       fifo_mem_q [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       level_q, level_d;
   logic             ampPWM_q, ampPWM_d;
   logic             ampSD_q;
   logic             mclk_q, mclk_d;
   logic             underrun_q, underrun_d;

   logic             bit_tick;
   logic             sample_load;
   logic             push;
   logic             pop;
   logic [8:0]       sum;

   // Ready depends only on the registered level, so there is no
   // combinational path from din_valid to din_ready.
   assign din_ready  = (level_q < FIFO_DEPTH);
   assign fifo_level = level_q;
   assign mclk       = mclk_q;
   assign ampPWM     = ampPWM_q;
   assign ampSD      = ampSD_q;
   assign underrun   = underrun_q;

   always_comb begin
      bit_tick    = enable && (div_cnt_q == DIV_LAST);
      sample_load = bit_tick && (bit_cnt_q == BIT_LAST);
      push        = din_valid && din_ready;
      // Pop decision uses the pre-push level: a sample pushed into an empty
      // FIFO on a load cycle is not visible to that load.
      pop         = sample_load && (level_q != 3'd0);
      // Modulator step always uses the sample held before any load this cycle.
      sum         = {1'b0, acc_q} + {1'b0, cur_sample_q};

      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      acc_d        = acc_q;
      ampPWM_d     = ampPWM_q;
      cur_sample_d = cur_sample_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      underrun_d   = sample_load && (level_q == 3'd0);

      if (!enable) begin
         div_cnt_d = '0;
         bit_cnt_d = '0;
         acc_d     = 8'd0;
         ampPWM_d  = 1'b0;
      end else begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
         if (bit_tick) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_ONE;
            acc_d     = sum[7:0];
            ampPWM_d  = sum[8];
         end
      end

      // mclk is registered from the next divider value so it lines up with
      // div_cnt_q: high while the visible phase is in the first half.
      mclk_d = enable && (div_cnt_d < DIV_HALF);

      if (pop) begin
         cur_sample_d = fifo_mem_q[rd_ptr_q];
         rd_ptr_d     = rd_ptr_q + 2'd1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 2'd1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 3'd1;
         2'b01:   level_d = level_q - 3'd1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         acc_q        <= 8'd0;
         cur_sample_q <= SILENCE;
         wr_ptr_q     <= 2'd0;
         rd_ptr_q     <= 2'd0;
         level_q      <= 3'd0;
         ampPWM_q     <= 1'b0;
         ampSD_q      <= 1'b0;
         mclk_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         acc_q        <= acc_d;
         cur_sample_q <= cur_sample_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         ampPWM_q     <= ampPWM_d;
         ampSD_q      <= enable;
         mclk_q       <= mclk_d;
         underrun_q   <= underrun_d;
      end
   end

   // Storage needs no reset: entries are only read after being written,
   // and the pointers/level are cleared by reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= din;
      end
   end

endmodule
`default_nettype wire

// File: doc/audio_pdm_tx.md
AUDIO_PDM_TX -- requirements
Module: audio_pdm_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per PDM bit period (min 2, even).
REQ-002 SHALL have parameter OSR, default 64, meaning PDM bits per PCM sample (min 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 resets on next clk edge).
REQ-005 SHALL have port din  input  8  PCM sample, offset-binary unsigned (0x80 = silence).
REQ-006 SHALL have port din_valid  input  1  producer asserts when din holds a sample.
REQ-007 SHALL have port din_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port enable  input  1  playback enable.
REQ-009 SHALL have port mclk  output  1  PDM bit clock, high for first CLK_DIV/2 clk cycles of each bit period.
REQ-010 SHALL have port ampPWM  output  1  registered PDM bitstream to amplifier.
REQ-011 SHALL have port ampSD  output  1  amplifier shutdown-not, registered copy of enable.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a sample load finds the FIFO empty.
REQ-013 SHALL have port fifo_level  output  3  FIFO occupancy, 0..4.

Function
REQ-014 SHALL contain a 4-entry FIFO; push when din_valid & din_ready; din_ready = (fifo_level < 4), driven from registered level only.
REQ-015 SHALL accept pushes regardless of enable; a push at full SHALL be impossible (ready low), no overwrite.
REQ-016 SHALL hold a divider counter div_cnt 0..CLK_DIV-1 wrapping to 0; bit_tick = enable & (div_cnt == CLK_DIV-1).
REQ-017 SHALL hold bit_cnt 0..OSR-1, incremented on bit_tick, wrapping to 0; sample_load = bit_tick & (bit_cnt == OSR-1).
REQ-018 On sample_load with fifo_level>0 SHALL pop head into cur_sample; with fifo_level=0 SHALL keep cur_sample and pulse underrun for exactly that cycle.
REQ-019 Push and pop in the same cycle SHALL leave fifo_level unchanged and preserve order; push into empty FIFO on a sample_load cycle SHALL NOT be popped that cycle (underrun fires).
REQ-020 SHALL implement first-order sigma-delta: on bit_tick sum[8:0] = acc[7:0] + cur_sample; ampPWM <= sum[8]; acc <= sum[7:0].
REQ-021 The sigma-delta step on a sample_load cycle SHALL use the cur_sample value before the load.
REQ-022 Ones density SHALL be exactly cur_sample/256 per 256 consecutive bit_ticks with constant cur_sample.
REQ-023 While enable=0: div_cnt, bit_cnt, acc SHALL be held at 0; ampPWM=0; mclk=0; ampSD=0 one cycle after enable falls; FIFO contents and cur_sample retained.
REQ-024 On enable rising, the first bit_tick SHALL occur CLK_DIV cycles later; first sample_load after OSR bit_ticks.
REQ-025 fifo_level SHALL be a registered count updated every push/pop.

Reset
REQ-026 reset=0 SHALL clear FIFO (level 0), div_cnt, bit_cnt, acc to 0; cur_sample to 0x80.
REQ-027 During/after reset SHALL drive ampPWM=0, ampSD=0, mclk=0, underrun=0, din_ready=1 on the cycle after reset edge.
REQ-028 Reset asserted mid-stream SHALL discard queued samples and any pending load without an underrun pulse.

Verification (bench uses CLK_DIV=4, OSR=8)
REQ-029 Reset: reset=0 for 3 cycles, enable=1 -> ampPWM=0, ampSD=0, mclk=0, fifo_level=0, din_ready=1, underrun=0.
REQ-030 Fill: enable=0, din_valid=1 for 6 cycles with 0x10..0x15 -> 0x10..0x13 accepted, fifo_level=4, din_ready=0 from the cycle after the 4th push.
REQ-031 Density: push 0x40 twice, enable=1 -> after first load ampPWM per bit_tick repeats 0,0,0,1; exactly 2 ones per 8-bit sample.
REQ-032 Underrun/idle: empty FIFO, enable=1 -> ampPWM alternates 0,1 (cur_sample 0x80); underrun pulses 1 cycle every 32 clk cycles; cur_sample stays 0x80.
REQ-033 Order/simultaneous: level=1 with 0xFF queued, push 0x00 on a sample_load cycle -> level stays 1, next sample 0xFF gives 7 ones in 8 bits, then 0x00 gives all zeros.
REQ-034 Mid-stream reset: level=3, enable=1, reset=0 one cycle -> next cycle level=0, ampPWM=0, ampSD=0, no underrun pulse; after release and enable, output resumes at 0x80 pattern.
